// File: rtl/data_sync_controller.sv
// data_sync_controller: toggle req/ack CDC receiver that captures a quasi-static bus and offers it valid/ready
// bus_synchronizer ports: clk, reset (async active-low), d (async in), q (synchronized out)
// data_sync_controller ports: clk, reset (async active-low), unsync_bus/req_toggle (source side),
//   sync_bus/sync_valid/dest_ready (consumer side), ack_toggle (back to source), overrun/overrun_clear
module bus_synchronizer #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [BUS_WIDTH-1:0] q
);
  logic [BUS_WIDTH-1:0] stage_q [STAGE_COUNT];
  logic [BUS_WIDTH-1:0] stage_d [STAGE_COUNT];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGE_COUNT; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < STAGE_COUNT; i++) stage_q[i] <= '0;
    else for (int i = 0; i < STAGE_COUNT; i++) stage_q[i] <= stage_d[i];
  assign q = stage_q[STAGE_COUNT-1];
endmodule

module data_sync_controller #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 req_toggle,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  input  logic                 dest_ready,
  output logic                 ack_toggle,
  output logic                 overrun,
  input  logic                 overrun_clear
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic req_sync, req_prev_q, req_pulse, capture, consume;
  logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
  logic sync_valid_q, sync_valid_d, ack_q, ack_d, overrun_q, overrun_d;
  bus_synchronizer #(.STAGE_COUNT(STAGE_COUNT), .BUS_WIDTH(1)) u_req_sync (
    .clk(clk), .reset(reset), .d(req_toggle), .q(req_sync)
  );
  assign req_pulse = req_sync ^ req_prev_q;
  // A pulse in HOLD is a protocol violation: the new word is dropped, never deferred.
  always_comb begin
    capture = (state_q == IDLE) && req_pulse;
    consume = (state_q == HOLD) && dest_ready;
    state_d = capture ? HOLD : consume ? IDLE : state_q;
    sync_bus_d = capture ? unsync_bus : sync_bus_q;
    sync_valid_d = (state_d == HOLD);
    ack_d = ack_q ^ consume;
    overrun_d = ((state_q == HOLD) && req_pulse) || (overrun_q && !overrun_clear);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      req_prev_q <= 1'b0;
      sync_bus_q <= '0;
      sync_valid_q <= 1'b0;
      ack_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_prev_q <= req_sync;
      sync_bus_q <= sync_bus_d;
      sync_valid_q <= sync_valid_d;
      ack_q <= ack_d;
      overrun_q <= overrun_d;
    end
  assign sync_bus = sync_bus_q;
  assign sync_valid = sync_valid_q;
  assign ack_toggle = ack_q;
  assign overrun = overrun_q;
endmodule

// File: doc/data_sync_controller.md
# data_sync_controller

Destination-domain controller that moves multi-bit words across a clock boundary with a toggle request/acknowledge handshake. It runs the single request bit through an internal `bus_synchronizer` (`BUS_WIDTH = 1`) and turns each synchronized toggle into a one-cycle capture event. It then latches the quasi-static source bus into a hold register and presents it to the local consumer with a valid/ready handshake. It sits between any slow-to-fast or fast-to-slow register path and its consumer, for example configuration words entering the system domain.

## Interface
- `STAGE_COUNT`, 2: synchronizer depth for the request bit; must be ≥ 2.
- `BUS_WIDTH`, 8: width of the transferred word.

- `clk`  in  1  destination-domain clock.
- `reset`  in  1  asynchronous, active-low reset.
- `unsync_bus`  in  `BUS_WIDTH`  source word, held stable by the source from its request toggle until the matching ack toggle.
- `req_toggle`  in  1  source request; it inverts once per new word and is asynchronous to `clk`.
- `sync_bus`  out  `BUS_WIDTH`  captured word.
- `sync_valid`  out  1  `sync_bus` holds an unconsumed word.
- `dest_ready`  in  1  consumer accepts the word when `sync_valid` and `dest_ready` are both 1.
- `ack_toggle`  out  1  inverts once per consumed word; the source synchronizes it in its own domain.
- `overrun`  out  1  sticky flag for a protocol violation.
- `overrun_clear`  in  1  synchronous clear of `overrun`.

## Operation
- Request path: `req_toggle` passes through the `bus_synchronizer` instance to give `req_sync`. An extra flop `req_prev` holds the previous value, and `req_pulse` = `req_sync` XOR `req_prev`.
- State machine with two states:
  - IDLE: `sync_valid` = 0. On `req_pulse`, load `unsync_bus` into the hold register and go to HOLD.
  - HOLD: `sync_valid` = 1 and `sync_bus` stays stable. When `dest_ready` = 1 the word is consumed: go to IDLE and invert `ack_toggle` on the same edge.
- `unsync_bus` is sampled only on the `req_pulse` edge. It never passes through multi-flop synchronization; stability comes from the handshake.
- `sync_bus` keeps the last captured word while in IDLE. It is never cleared except by reset.
- Overrun:
  - `req_pulse` in HOLD sets `overrun`.
  - The new word is dropped; the held word and the state are unaffected.
  - If `dest_ready` is also 1 in that cycle, the held word is still consumed, `ack_toggle` flips once, and the controller returns to IDLE. The dropped word is not captured later.
- `overrun_clear` clears `overrun` on the next edge. If set and clear occur in the same cycle, set wins.
- `dest_ready` in IDLE has no effect.

## Timing
- Reset (`reset` = 0, asynchronous) forces every flop to its reset value:
  - all synchronizer stages, `req_prev`, state = IDLE;
  - `sync_bus` = 0, `sync_valid` = 0, `ack_toggle` = 0, `overrun` = 0.
- Reset release requires the source to have `req_toggle` = 0, which guarantees no spurious pulse.
- Reset mid-HOLD discards the word. The source domain must be reset together with this block.
- Latency, for a toggle that meets setup at edge 1:
  - `req_sync` changes after edge `STAGE_COUNT`;
  - `req_pulse` is high for exactly one cycle;
  - capture happens at edge `STAGE_COUNT`+1, and `sync_valid` rises after it. That is 3 edges with the default depth.
- `sync_valid` falls, and `ack_toggle` flips, on the first edge where `sync_valid` and `dest_ready` are both 1. Minimum HOLD occupancy is 1 cycle.
- Throughput is bounded by the round trip: synchronizer depth in both domains plus the consumer's stall.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single transfer, `STAGE_COUNT` = 2, `BUS_WIDTH` = 8, `dest_ready` = 1:
  - stimulus: `unsync_bus` = 8'hA5, toggle `req_toggle` 0→1 before edge 1;
  - response: `sync_valid` high after edge 3 for exactly 1 cycle, `sync_bus` = 8'hA5, `ack_toggle` goes 0→1 after edge 4.
- Back-pressure:
  - stimulus: `dest_ready` = 0 for 5 cycles after capture, then 1;
  - response: `sync_valid` and `sync_bus` = 8'h3C stay stable for the whole stall, then one ack flip and a return to IDLE.
- Back-to-back words:
  - stimulus: 8'h01, 8'h02, 8'h03, with each toggle issued only after the matching ack;
  - response: three captures in order, `ack_toggle` sequence 1, 0, 1, `overrun` stays 0.
- Overrun:
  - stimulus: toggle again while in HOLD with `dest_ready` = 0 and a new bus value 8'hFF;
  - response: `overrun` = 1, held word 8'h11 unchanged, 8'hFF never appears. Then assert `overrun_clear` together with a fresh violation and check `overrun` stays 1.
- Reset mid-HOLD:
  - stimulus: assert `reset` = 0 asynchronously between edges while `sync_valid` = 1;
  - response: all outputs go to 0 immediately with no clock edge, and no pulse appears after release.
- Depth check, `STAGE_COUNT` = 4:
  - stimulus: same as the single-transfer case;
  - response: `sync_valid` rises after edge 5.
